serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first, with borrow and overflow
module serial_subtractor #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow_out,
    output logic                overflow
);

    // Counter only needs to reach NUM_BITS-1; NUM_BITS >= 2 keeps CNT_W >= 1.
    localparam int                CNT_W    = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_BITS-1:0] a_sr;
    logic [NUM_BITS-1:0] b_sr;
    logic                br;
    logic [CNT_W-1:0]    cnt;

    logic                a_bit;
    logic                b_bit;
    logic                d_bit;
    logic                br_next;
    logic                last_bit;

    // One-bit full-subtractor slice on the current LSBs of the operand shift registers.
    always_comb begin
        a_bit    = a_sr[0];
        b_bit    = b_sr[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        last_bit = (cnt == CNT_LAST);
    end

    // Status flags are pure decodes of the registered state, so no input reaches them combinationally.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // Main sequencer: load on accepted start, shift one bit per clock, publish flags on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Operands are only sampled here; input activity at any other time is invisible.
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= borrow_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // start is deliberately not looked at here so the operation in flight is untouched.
                    a_sr <= {1'b0, a_sr[NUM_BITS-1:1]};
                    b_sr <= {1'b0, b_sr[NUM_BITS-1:1]};
                    br   <= br_next;
                    // Result bits enter at the MSB so the final bit lands in position NUM_BITS-1.
                    diff <= {d_bit, diff[NUM_BITS-1:1]};
                    if (last_bit) begin
                        // On the last bit a_bit/b_bit are the captured sign bits and d_bit is the result sign.
                        borrow_out <= br_next;
                        overflow   <= (a_bit != b_bit) && (d_bit != a_bit);
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
